// File: rtl/sqz_mem_pkg.sv
// Shared types and arithmetic for the SqueezeNet memory / MAC slice.
package sqz_mem_pkg;

   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

   // Signed add clamped to the range of a dw-bit two's-complement word (dw <= 30).
   function automatic int sat_add(input int a, input int b, input int unsigned dw);
      int hi;
      int lo;
      int s;
      hi = (1 << (dw - 1)) - 1;
      lo = -(1 << (dw - 1));
      s  = a + b;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/sqz_sat_add.sv
// Combinational signed saturating adder for DATA_WIDTH-bit words.
module sqz_sat_add
   import sqz_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] y_o
);

   assign y_o = DATA_WIDTH'(sat_add(int'($signed(a_i)), int'($signed(b_i)), DATA_WIDTH));

endmodule

// File: rtl/fmap_acc_ram.sv
// Simple dual-port feature-map RAM: store or saturating-accumulate write port,
// registered read port, and a hardware sequencer that clears every word to 0.
module fmap_acc_ram
   import sqz_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  reset_n,
   input  logic                  clr_start,
   output logic                  clr_busy,
   input  logic                  wr_en,
   input  logic                  wr_acc,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   clr_state_e            state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  clr_busy_q;

   logic                  s2_v_q;
   logic                  s2_acc_q;
   logic [ADDR_WIDTH-1:0] s2_addr_q;
   logic [DATA_WIDTH-1:0] s2_data_q;
   logic [DATA_WIDTH-1:0] s2_old_q;
   logic [DATA_WIDTH-1:0] s2_sum;
   logic [DATA_WIDTH-1:0] s2_res;

   logic                  rd_valid_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic                  wr_take;
   logic                  fwd;

   sqz_sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
      .a_i (s2_old_q),
      .b_i (s2_data_q),
      .y_o (s2_sum)
   );

   assign s2_res  = s2_acc_q ? s2_sum : s2_data_q;
   assign wr_take = wr_en && (state_q == CLR_IDLE) && !clr_start;
   // S1 samples the array on the same edge S2 commits, so a same-address S2 result must be forwarded.
   assign fwd     = s2_v_q && (s2_addr_q == wr_addr);

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= CLR_IDLE;
         cnt_q      <= '0;
         clr_busy_q <= 1'b0;
         s2_v_q     <= 1'b0;
         s2_acc_q   <= 1'b0;
         s2_addr_q  <= '0;
         s2_data_q  <= '0;
         s2_old_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         case (state_q)
            CLR_IDLE: begin
               if (clr_start) begin
                  state_q    <= CLR_RUN;
                  cnt_q      <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            CLR_RUN: begin
               if (&cnt_q) begin
                  state_q    <= CLR_IDLE;
                  cnt_q      <= '0;
                  clr_busy_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= CLR_IDLE;
         endcase

         s2_v_q <= wr_take;
         if (wr_take) begin
            s2_acc_q  <= wr_acc;
            s2_addr_q <= wr_addr;
            s2_data_q <= wr_data;
            s2_old_q  <= fwd ? s2_res : mem[wr_addr];
         end

         rd_valid_q <= rd_en;
         if (rd_en) rd_data_q <= mem[rd_addr];
      end
   end

   always_ff @(posedge Clk) begin
      if (state_q == CLR_RUN) mem[cnt_q] <= '0;
      else if (s2_v_q)        mem[s2_addr_q] <= s2_res;
   end

   assign clr_busy = clr_busy_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fmap_acc_ram.sv
// Randomised bench for fmap_acc_ram against a program-order memory model.
module tb_fmap_acc_ram;

   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          clr_start = 1'b0;
   logic          clr_busy;
   logic          wr_en     = 1'b0;
   logic          wr_acc    = 1'b0;
   logic [AW-1:0] wr_addr   = '0;
   logic [DW-1:0] wr_data   = '0;
   logic          rd_en     = 1'b0;
   logic [AW-1:0] rd_addr   = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fmap_acc_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .Clk       (clk),
      .reset_n   (rst_n),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .wr_en     (wr_en),
      .wr_acc    (wr_acc),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: 'lg' is the memory in program order, 'vis' is what a read sees.
   typedef struct {
      int            due;
      int            addr;
      logic [DW-1:0] val;
   } pend_t;

   logic [DW-1:0] vis [DEPTH];
   logic [DW-1:0] lg  [DEPTH];
   pend_t         pq  [$];
   int            cyc      = 0;
   int            clr_left = 0;
   logic          exp_busy  = 1'b0;
   logic          exp_valid = 1'b0;
   logic [DW-1:0] exp_data  = '0;
   logic [DW-1:0] mval;

   function automatic logic [DW-1:0] ref_sat(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int s;
      int hi;
      int lo;
      s  = int'($signed(a)) + int'($signed(b));
      hi = (1 << (DW - 1)) - 1;
      lo = -(1 << (DW - 1));
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
      return DW'(s);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pq.delete();
         clr_left  = 0;
         exp_busy  = 1'b0;
         exp_valid = 1'b0;
         exp_data  = '0;
         for (int i = 0; i < DEPTH; i++) lg[i] = vis[i];
      end else begin
         cyc++;
         exp_valid = rd_en;
         if (rd_en) exp_data = vis[rd_addr];
         while (pq.size() > 0 && pq[0].due <= cyc) begin
            vis[pq[0].addr] = pq[0].val;
            void'(pq.pop_front());
         end
         if (clr_left > 0) begin
            vis[DEPTH - clr_left] = '0;
            lg[DEPTH - clr_left]  = '0;
            clr_left--;
         end else if (clr_start) begin
            clr_left = DEPTH;
         end else if (wr_en) begin
            mval = wr_acc ? ref_sat(lg[wr_addr], wr_data) : wr_data;
            lg[wr_addr] = mval;
            pq.push_back('{cyc + 1, int'(wr_addr), mval});
         end
         exp_busy = (clr_left > 0);
      end
   end

   always @(negedge clk) begin
      check("cyc_rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
      check("cyc_clr_busy", {31'd0, clr_busy}, {31'd0, exp_busy});
      check("cyc_rd_data", {24'd0, rd_data}, {24'd0, exp_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en     = 1'b0;
      wr_acc    = 1'b0;
      rd_en     = 1'b0;
      clr_start = 1'b0;
   endtask

   task automatic wr(input int a, input int d, input bit acc);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = DW'(d);
      wr_acc  = acc;
      tick();
      wr_en  = 1'b0;
      wr_acc = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input int a, input int exp);
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      tick();
      rd_en = 1'b0;
      @(negedge clk);
      check({nm, "_valid"}, {31'd0, rd_valid}, 32'd1);
      check(nm, {24'd0, rd_data}, exp);
   endtask

   task automatic run_clear(input string nm, input bit traffic, output int last_wa);
      int n;
      n = 0;
      last_wa = -1;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int k = 0; k < DEPTH + 200; k++) begin
         @(negedge clk);
         if (!clr_busy) break;
         n++;
         @(posedge clk);
         #1;
         if (traffic && n < DEPTH - 1) begin
            wr_en   = $urandom_range(1);
            wr_acc  = $urandom_range(1);
            wr_addr = AW'($urandom);
            wr_data = DW'($urandom);
            rd_en   = $urandom_range(1);
            rd_addr = AW'($urandom);
            if (wr_en) last_wa = int'(wr_addr);
         end else begin
            idle();
         end
      end
      check(nm, n, DEPTH);
      idle();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int last_wa;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("reset_clr_busy", {31'd0, clr_busy}, 32'd0);
      check("reset_rd_data", {24'd0, rd_data}, 32'd0);
      tick();

      run_clear("init_clear_len", 1'b0, last_wa);

      wr(5, 8'h12, 1'b0);
      tick();
      rd_chk("plain_wr_rd", 5, 8'h12);

      wr(8'h10, 8'h03, 1'b0);
      for (int i = 0; i < 4; i++) wr(8'h10, 8'h05, 1'b1);
      tick();
      rd_chk("acc_fwd_x4", 8'h10, 8'h17);

      wr(8'h30, 8'h70, 1'b0);
      wr(8'h30, 8'h70, 1'b1);
      wr(8'h31, 8'h90, 1'b0);
      wr(8'h31, 8'h90, 1'b1);
      wr(8'h32, 8'hF0, 1'b0);
      wr(8'h32, 8'h05, 1'b1);
      tick();
      rd_chk("sat_pos", 8'h30, 8'h7F);
      rd_chk("sat_neg", 8'h31, 8'h80);
      rd_chk("acc_neg", 8'h32, 8'hF5);

      wr(8'h20, 8'h11, 1'b0);
      tick();
      tick();
      wr(8'h20, 8'h44, 1'b0);
      rd_chk("rd_during_commit_old", 8'h20, 8'h11);
      rd_chk("rd_after_commit_new", 8'h20, 8'h44);

      for (int c = 0; c < 1500; c++) begin
         wr_en   = ($urandom_range(3) != 0);
         wr_acc  = $urandom_range(1);
         wr_addr = AW'($urandom_range(7));
         wr_data = DW'($urandom);
         rd_en   = $urandom_range(1);
         rd_addr = AW'($urandom_range(7));
         tick();
      end
      idle();
      tick();

      for (int i = 0; i < DEPTH; i++) begin
         wr_en   = 1'b1;
         wr_acc  = 1'b0;
         wr_addr = AW'(i);
         wr_data = DW'($urandom);
         tick();
      end
      idle();
      run_clear("clear_len", 1'b1, last_wa);
      rd_chk("clear_first", 0, 0);
      rd_chk("clear_last", DEPTH - 1, 0);
      if (last_wa >= 0) rd_chk("clear_ignored_wr", last_wa, 0);
      for (int i = 0; i < 16; i++) rd_chk("clear_rand", $urandom_range(DEPTH - 1), 0);

      for (int i = 0; i < 256; i++) wr(i, i | 1, 1'b0);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      repeat (100) tick();
      rst_n = 1'b0;
      #1;
      check("abort_busy_low", {31'd0, clr_busy}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      rd_chk("abort_addr0", 0, 0);
      rd_chk("abort_addr99", 99, 0);
      rd_chk("abort_addr100", 100, 8'h65);
      rd_chk("abort_addr200", 200, 8'hC9);
      rd_chk("abort_addr255", 255, 8'hFF);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
